// File: rtl/cacheline_burst_adapter_pkg.sv
// Shared constants and types for the cacheline-to-burst adapter:
// line/beat geometry, adapter states and the line-alignment helper.
package cacheline_burst_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CNT_WIDTH   = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } adapter_state_t;

  typedef logic [LINE_WIDTH-1:0]  line_t;
  typedef logic [BURST_WIDTH-1:0] beat_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;

  // Clear the byte offset within the line.
  function automatic addr_t line_align(input addr_t a);
    return a & ~addr_t'((1 << OFFSET_BITS) - 1);
  endfunction

endpackage

// File: rtl/cacheline_burst_adapter_if.sv
// Cache line port plus memory burst port of the adapter.
// slave = the adapter; master = the cache and memory environment around it.
interface cacheline_burst_adapter_if;
  import cacheline_burst_pkg::*;

  addr_t line_addr_i;
  logic  line_read_i;
  logic  line_write_i;
  line_t line_wdata_i;
  line_t line_rdata_o;
  logic  line_resp_o;

  addr_t burst_addr_o;
  logic  burst_read_o;
  logic  burst_write_o;
  beat_t burst_wdata_o;
  beat_t burst_rdata_i;
  logic  burst_resp_i;

  modport slave (
    input  line_addr_i, line_read_i, line_write_i, line_wdata_i,
    output line_rdata_o, line_resp_o,
    output burst_addr_o, burst_read_o, burst_write_o, burst_wdata_o,
    input  burst_rdata_i, burst_resp_i
  );

  modport master (
    output line_addr_i, line_read_i, line_write_i, line_wdata_i,
    input  line_rdata_o, line_resp_o,
    input  burst_addr_o, burst_read_o, burst_write_o, burst_wdata_o,
    output burst_rdata_i, burst_resp_i
  );

endinterface

// File: rtl/cacheline_burst_adapter.sv
// Turns one 256-bit line read/write into a 4-beat 64-bit memory burst and
// answers the cache with a single-cycle line response.
module cacheline_burst_adapter
  import cacheline_burst_pkg::*;
(
  input logic clk,
  input logic rst,
  cacheline_burst_adapter_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS - 1);

  adapter_state_t       state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  addr_t                addr_reg, addr_next;
  line_t                line_buf_reg, line_buf_next;
  line_t                rdata_reg, rdata_next;
  logic                 resp_reg, resp_next;

  // One buffer serves both read assembly and write serialization.
  beat_t slot [BEATS];

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_slot
      assign slot[gi] = line_buf_reg[gi*BURST_WIDTH +: BURST_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      line_buf_reg <= '0;
      rdata_reg    <= '0;
      resp_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      addr_reg     <= addr_next;
      line_buf_reg <= line_buf_next;
      rdata_reg    <= rdata_next;
      resp_reg     <= resp_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    addr_next     = addr_reg;
    line_buf_next = line_buf_reg;
    rdata_next    = rdata_reg;
    resp_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.line_read_i) begin
          addr_next  = line_align(bus.line_addr_i);
          cnt_next   = '0;
          state_next = RD_BURST;
        end else if (bus.line_write_i) begin
          addr_next     = line_align(bus.line_addr_i);
          cnt_next      = '0;
          line_buf_next = bus.line_wdata_i;
          state_next    = WR_BURST;
        end
      end

      RD_BURST: begin
        if (bus.burst_resp_i) begin
          line_buf_next[cnt_reg*BURST_WIDTH +: BURST_WIDTH] = bus.burst_rdata_i;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_BEAT) begin
            // Publish the full line together with the response pulse.
            rdata_next = line_buf_next;
            resp_next  = 1'b1;
            state_next = DONE;
          end
        end
      end

      WR_BURST: begin
        if (bus.burst_resp_i) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_BEAT) begin
            resp_next  = 1'b1;
            state_next = DONE;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.line_rdata_o  = rdata_reg;
  assign bus.line_resp_o   = resp_reg;
  assign bus.burst_addr_o  = addr_reg;
  assign bus.burst_read_o  = (state_reg == RD_BURST);
  assign bus.burst_write_o = (state_reg == WR_BURST);
  assign bus.burst_wdata_o = (state_reg == WR_BURST) ? slot[cnt_reg] : '0;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Directed and randomized line transactions against a queue-based memory
// model; each transaction prints one line.
module tb_cacheline_burst_adapter;
  import cacheline_burst_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_burst_adapter_if bus();

  cacheline_burst_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    total = 0;
  int    bad   = 0;
  line_t last_rd_line = '0;
  bit    resp_pat[$];
  beat_t beat_q[$];

  task automatic chk(input string tag, input line_t obs, input line_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < LINE_WIDTH / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic idle_inputs();
    bus.line_addr_i   = '0;
    bus.line_read_i   = 1'b0;
    bus.line_write_i  = 1'b0;
    bus.line_wdata_i  = '0;
    bus.burst_rdata_i = '0;
    bus.burst_resp_i  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/rdata"}, bus.line_rdata_o, '0);
    chk1({tag, "/resp"}, bus.line_resp_o, 1'b0);
    chk({tag, "/baddr"}, line_t'(bus.burst_addr_o), '0);
    chk1({tag, "/bread"}, bus.burst_read_o, 1'b0);
    chk1({tag, "/bwrite"}, bus.burst_write_o, 1'b0);
    chk({tag, "/bwdata"}, line_t'(bus.burst_wdata_o), '0);
  endtask

  // Called at a negedge with the adapter idle. Acts as cache and memory.
  // exp_lat counts cycles from the request cycle (=1) to the response cycle.
  task automatic run_txn(input bit do_rd, input bit do_wr, input addr_t addr,
                         input line_t wd, input int gap_pct, input int exp_lat,
                         input string tag);
    int    acc = 0;
    int    ncyc;
    bit    done = 1'b0;
    bit    r;
    beat_t beat;
    line_t got = '0;
    addr_t exp_addr;
    exp_addr = (addr >> 5) << 5;

    bus.line_read_i  = do_rd;
    bus.line_write_i = do_wr;
    bus.line_addr_i  = addr;
    bus.line_wdata_i = wd;
    bus.burst_resp_i = 1'b0;
    @(posedge clk); @(negedge clk);
    ncyc = 2;

    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (acc < BEATS) begin
        chk1({tag, "/bread"}, bus.burst_read_o, do_rd);
        chk1({tag, "/bwrite"}, bus.burst_write_o, !do_rd);
        chk({tag, "/baddr"}, line_t'(bus.burst_addr_o), line_t'(exp_addr));
        chk1({tag, "/early_resp"}, bus.line_resp_o, 1'b0);
        if (!do_rd)
          chk({tag, "/bwdata"}, line_t'(bus.burst_wdata_o), line_t'(wd[acc*64 +: 64]));
        if (resp_pat.size() > 0) r = resp_pat.pop_front();
        else r = ($urandom_range(99) >= gap_pct);
        beat = (beat_q.size() > 0) ? beat_q[0] : {$urandom, $urandom};
        if (r && beat_q.size() > 0) void'(beat_q.pop_front());
        bus.burst_resp_i  = r;
        bus.burst_rdata_i = beat;
        if (r) begin
          got[acc*64 +: 64] = beat;
          acc++;
        end
        @(posedge clk); @(negedge clk);
        ncyc++;
      end else begin
        chk1({tag, "/resp"}, bus.line_resp_o, 1'b1);
        chk1({tag, "/done_bread"}, bus.burst_read_o, 1'b0);
        chk1({tag, "/done_bwrite"}, bus.burst_write_o, 1'b0);
        if (do_rd) last_rd_line = got;
        chk({tag, "/line"}, bus.line_rdata_o, last_rd_line);
        if (exp_lat > 0) chk({tag, "/lat"}, line_t'(ncyc), line_t'(exp_lat));
        bus.line_read_i  = 1'b0;
        bus.line_write_i = 1'b0;
        bus.burst_resp_i = 1'($urandom_range(1));
        @(posedge clk); @(negedge clk);
        chk1({tag, "/resp_once"}, bus.line_resp_o, 1'b0);
        chk1({tag, "/idle_bread"}, bus.burst_read_o, 1'b0);
        chk1({tag, "/idle_bwrite"}, bus.burst_write_o, 1'b0);
        bus.burst_resp_i = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s/timeout: no line response within bound", tag);
    end
    $display("txn %s rd=%0b wr=%0b addr=%h cycles=%0d line=%h", tag, do_rd, do_wr,
             addr, ncyc, do_rd ? last_rd_line : wd);
  endtask

  initial begin
    line_t wd;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    $display("txn reset outputs checked");

    // Back-to-back read beats, unaligned address.
    beat_q = '{64'h1111111111111111, 64'h2222222222222222,
               64'h3333333333333333, 64'h4444444444444444};
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0, 0, 6, "rd_b2b");
    chk("rd_b2b/assembled", bus.line_rdata_o,
        {64'h4444444444444444, 64'h3333333333333333,
         64'h2222222222222222, 64'h1111111111111111});

    // Write with gaps in the accept pattern.
    wd = {64'hD3D3D3D3D3D3D3D3, 64'hD2D2D2D2D2D2D2D2,
          64'hD1D1D1D1D1D1D1D1, 64'hD0D0D0D0D0D0D0D0};
    resp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_txn(1'b0, 1'b1, 32'h0000_2040, wd, 0, 9, "wr_gap");

    // Both requests high: read must win.
    run_txn(1'b1, 1'b1, 32'h0000_3FFF, rand_line(), 0, 6, "rd_wr_both");

    // Reset in the middle of a read after two beats.
    bus.line_read_i = 1'b1;
    bus.line_addr_i = 32'h0000_4400;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bus.burst_resp_i  = 1'b1;
      bus.burst_rdata_i = {$urandom, $urandom};
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    bus.burst_resp_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_all_zero("midrd_rst");
    rst = 1'b0;
    bus.line_read_i = 1'b0;
    last_rd_line = '0;
    @(posedge clk); @(negedge clk);
    chk1("midrd_rst/no_resp", bus.line_resp_o, 1'b0);
    chk1("midrd_rst/idle", bus.burst_read_o, 1'b0);
    $display("txn reset mid-read checked");
    run_txn(1'b1, 1'b0, 32'h0000_4400, '0, 0, 6, "rd_after_rst");

    // Writeback then refill, as a cache miss on a dirty line would do.
    run_txn(1'b0, 1'b1, 32'h0000_0080, rand_line(), 0, 6, "wb_0x80");
    run_txn(1'b1, 1'b0, 32'h0000_0100, '0, 0, 6, "fill_0x100");

    // Stray beat responses while idle must not start anything.
    for (int i = 0; i < 3; i++) begin
      bus.burst_resp_i  = 1'b1;
      bus.burst_rdata_i = {$urandom, $urandom};
      @(posedge clk); @(negedge clk);
      chk1("stray/bread", bus.burst_read_o, 1'b0);
      chk1("stray/bwrite", bus.burst_write_o, 1'b0);
      chk1("stray/resp", bus.line_resp_o, 1'b0);
      chk("stray/line", bus.line_rdata_o, last_rd_line);
    end
    bus.burst_resp_i = 1'b0;
    $display("txn stray idle responses checked");

    // Randomized traffic with random gaps.
    for (int t = 0; t < 24; t++) begin
      bit is_rd;
      is_rd = 1'($urandom_range(1));
      run_txn(is_rd, !is_rd, $urandom, rand_line(), $urandom_range(60), 0,
              $sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
